// File: rtl/tron_engine_if.sv
// tron_engine_if: player controls in, VGA pixel write and game status out.
// master = engine side, slave = host/board side.
`timescale 1ns/1ps
interface tron_engine_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int X_W         = 8,
  parameter int Y_W         = 7
);
  logic                   start;
  logic [NUM_PLAYERS-1:0] turn_left;
  logic [NUM_PLAYERS-1:0] turn_right;
  logic [X_W-1:0]         x;
  logic [Y_W-1:0]         y;
  logic [2:0]             colour;
  logic                   plot;
  logic [NUM_PLAYERS-1:0] alive;
  logic                   game_over;
  logic [1:0]             winner;
  logic                   winner_valid;
  logic [15:0]            step_count;

  modport master (
    input  start, turn_left, turn_right,
    output x, y, colour, plot, alive, game_over, winner, winner_valid, step_count
  );

  modport slave (
    output start, turn_left, turn_right,
    input  x, y, colour, plot, alive, game_over, winner, winner_valid, step_count
  );
endinterface

// File: rtl/tron_engine.sv
// tron_engine: light-cycle movement/collision engine for 1..4 players.
// Optional macro TRON_WALL_WRAP_EN: grid edges wrap instead of killing.
//
// state | meaning
// IDLE  | after reset, waiting for start
// INIT  | start positions loaded, plotting one start pixel per cycle
// WAIT  | step tick down-counter running
// MOVE  | apply pending turns, compute next cells
// CHECK | resolve wall / same-cell / swap deaths
// DRAW  | one slot per player, plot survivors
// OVER  | game finished, winner reported, start begins a new game
`timescale 1ns/1ps
module tron_engine #(
  parameter int NUM_PLAYERS = 2,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int GRID_W      = 160,
  parameter int GRID_H      = 120,
  parameter int STEP_DIV    = 2500000
) (
  input logic          clk,
  input logic          reset,
  tron_engine_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_WAIT, ST_MOVE, ST_CHECK, ST_DRAW, ST_OVER
  } state_t;

  localparam int TW = $clog2(STEP_DIV);
  localparam int SW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  // two spare bits: one for the sign on underflow, one so GRID_W itself fits
  localparam int XE = X_W + 2;
  localparam int YE = Y_W + 2;
  localparam logic [TW-1:0] TICK_LOAD = TW'(STEP_DIV - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_PLAYERS - 1);
  localparam logic [XE-1:0] GW_E      = XE'(GRID_W);
  localparam logic [YE-1:0] GH_E      = YE'(GRID_H);

  state_t                 state, state_nx;
  logic [TW-1:0]          tick;
  logic [SW-1:0]          slot;
  logic [X_W-1:0]         px [NUM_PLAYERS];
  logic [Y_W-1:0]         py [NUM_PLAYERS];
  logic [1:0]             dir [NUM_PLAYERS];
  logic [XE-1:0]          nx_r [NUM_PLAYERS];
  logic [YE-1:0]          ny_r [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] oob_r;
  logic [XE-1:0]          mv_x [NUM_PLAYERS];
  logic [YE-1:0]          mv_y [NUM_PLAYERS];
  logic [1:0]             mv_dir [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] mv_oob;
  logic [NUM_PLAYERS-1:0] alive, die;
  logic [NUM_PLAYERS-1:0] prev_l, prev_r, pend_l, pend_r;
  logic [15:0]            step_count;
  logic [1:0]             winner;
  logic                   winner_valid;
  logic [2:0]             alive_cnt;
  logic [1:0]             alive_idx;
  logic                   game_end;

  function automatic logic [X_W-1:0] start_x(int i);
    return X_W'((GRID_W * (i + 1)) / (NUM_PLAYERS + 1));
  endfunction

  function automatic logic [2:0] player_colour(int i);
    case (i)
      0:       return 3'b100;
      1:       return 3'b001;
      2:       return 3'b010;
      default: return 3'b110;
    endcase
  endfunction

  // turn resolution and one-cell advance for every player
  always_comb begin
    mv_oob = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      mv_dir[i] = dir[i];
      if (pend_r[i] && !pend_l[i])      mv_dir[i] = dir[i] + 2'd1;
      else if (pend_l[i] && !pend_r[i]) mv_dir[i] = dir[i] - 2'd1;
      mv_x[i] = {2'b00, px[i]};
      mv_y[i] = {2'b00, py[i]};
      case (mv_dir[i])
        2'd0:    mv_x[i] = mv_x[i] + XE'(1);
        2'd1:    mv_y[i] = mv_y[i] + YE'(1);
        2'd2:    mv_x[i] = mv_x[i] - XE'(1);
        default: mv_y[i] = mv_y[i] - YE'(1);
      endcase
      // MSB set means the step went below zero
      mv_oob[i] = mv_x[i][XE-1] || (mv_x[i] >= GW_E) ||
                  mv_y[i][YE-1] || (mv_y[i] >= GH_E);
`ifdef TRON_WALL_WRAP_EN
      if (mv_x[i][XE-1])       mv_x[i] = GW_E - XE'(1);
      else if (mv_x[i] >= GW_E) mv_x[i] = '0;
      if (mv_y[i][YE-1])       mv_y[i] = GH_E - YE'(1);
      else if (mv_y[i] >= GH_E) mv_y[i] = '0;
      mv_oob[i] = 1'b0;
`endif
    end
  end

  // simultaneous death resolution among players alive before this step
  always_comb begin
    die = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (alive[i] && oob_r[i]) die[i] = 1'b1;
      for (int j = 0; j < NUM_PLAYERS; j++) begin
        if (j != i && alive[i] && alive[j]) begin
          if (nx_r[i] == nx_r[j] && ny_r[i] == ny_r[j]) die[i] = 1'b1;
          if (nx_r[i] == {2'b00, px[j]} && ny_r[i] == {2'b00, py[j]} &&
              nx_r[j] == {2'b00, px[i]} && ny_r[j] == {2'b00, py[i]})
            die[i] = 1'b1;
        end
      end
    end
  end

  // survivor count and index of the last survivor found
  always_comb begin
    alive_cnt = '0;
    alive_idx = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (alive[i]) begin
        alive_cnt = alive_cnt + 3'd1;
        alive_idx = 2'(i);
      end
    end
    game_end = (NUM_PLAYERS == 1) ? (alive_cnt == 3'd0) : (alive_cnt <= 3'd1);
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nx = ST_INIT;
      ST_INIT:  if (slot == SLOT_LAST) state_nx = ST_WAIT;
      ST_WAIT:  if (tick == '0) state_nx = ST_MOVE;
      ST_MOVE:  state_nx = ST_CHECK;
      ST_CHECK: state_nx = ST_DRAW;
      ST_DRAW:  if (slot == SLOT_LAST) state_nx = game_end ? ST_OVER : ST_WAIT;
      ST_OVER:  if (bus.start) state_nx = ST_INIT;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // pixel write decode; combinational so reset removes plot immediately
  always_comb begin
    bus.x      = '0;
    bus.y      = '0;
    bus.colour = '0;
    bus.plot   = 1'b0;
    if (state == ST_INIT || state == ST_DRAW) begin
      bus.x      = px[slot];
      bus.y      = py[slot];
      bus.colour = player_colour(int'(slot));
      bus.plot   = (state == ST_INIT) || alive[slot];
    end
  end

  assign bus.alive        = alive;
  assign bus.game_over    = (state == ST_OVER);
  assign bus.winner       = winner;
  assign bus.winner_valid = winner_valid;
  assign bus.step_count   = step_count;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // step tick down-counter, reloaded whenever not waiting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                tick <= '0;
    else if (state != ST_WAIT) tick <= TICK_LOAD;
    else if (tick == '0)       tick <= TICK_LOAD;
    else                       tick <= tick - TW'(1);
  end

  // rising-edge turn capture, consumed by MOVE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_l <= '0;
      prev_r <= '0;
      pend_l <= '0;
      pend_r <= '0;
    end else begin
      prev_l <= bus.turn_left;
      prev_r <= bus.turn_right;
      pend_l <= (state == ST_MOVE) ? '0 : (pend_l | (bus.turn_left & ~prev_l));
      pend_r <= (state == ST_MOVE) ? '0 : (pend_r | (bus.turn_right & ~prev_r));
    end
  end

  // player positions, alive mask, step counter and result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        px[i]   <= '0;
        py[i]   <= '0;
        dir[i]  <= '0;
        nx_r[i] <= '0;
        ny_r[i] <= '0;
      end
      oob_r        <= '0;
      alive        <= '0;
      slot         <= '0;
      step_count   <= '0;
      winner       <= '0;
      winner_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_OVER: begin
          if (bus.start) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              px[i]  <= start_x(i);
              py[i]  <= Y_W'(GRID_H / 2);
              dir[i] <= (i % 2 == 0) ? 2'd0 : 2'd2;
            end
            alive        <= '1;
            slot         <= '0;
            step_count   <= '0;
            winner       <= '0;
            winner_valid <= 1'b0;
          end
        end
        ST_INIT, ST_DRAW: begin
          slot <= (slot == SLOT_LAST) ? '0 : slot + SW'(1);
          if (state == ST_DRAW && slot == SLOT_LAST && game_end) begin
            winner       <= (alive_cnt == 3'd1) ? alive_idx : 2'd0;
            winner_valid <= (alive_cnt == 3'd1);
          end
        end
        ST_MOVE: begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (alive[i]) begin
              nx_r[i]  <= mv_x[i];
              ny_r[i]  <= mv_y[i];
              oob_r[i] <= mv_oob[i];
              dir[i]   <= mv_dir[i];
            end
          end
          if (step_count != 16'hFFFF) step_count <= step_count + 16'd1;
        end
        ST_CHECK: begin
          alive <= alive & ~die;
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (alive[i] && !die[i]) begin
              px[i] <= nx_r[i][X_W-1:0];
              py[i] <= ny_r[i][Y_W-1:0];
            end
          end
          slot <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/tron_engine.md
Name: tron_engine

Overview:
- Parametrised movement/collision engine for the light-cycle game, successor to the fixed two-player tron controller.
- Supports 1..4 players, each with a 2-button relative steering scheme, on a configurable grid.
- Runs on a fixed step tick and emits one VGA pixel write per alive player per step, in the x/y/colour/plot form the 160x120 vga_adapter takes.
- Reports alive mask, game-over, winner and a step counter for the HEX time display.

Parameters:
- NUM_PLAYERS, 2, player count, legal 1..4
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- GRID_W, 160, grid columns; legal x is 0..GRID_W-1
- GRID_H, 120, grid rows; legal y is 0..GRID_H-1
- STEP_DIV, 2500000, clk cycles between steps (20 Hz at 50 MHz), minimum 4

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-low reset
- start  in  1  active-high; sampled each cycle
- turn_left  in  NUM_PLAYERS  per-player level input; a rising edge requests a left turn
- turn_right  in  NUM_PLAYERS  per-player level input; a rising edge requests a right turn
- x  out  X_W  pixel x for the VGA write
- y  out  Y_W  pixel y for the VGA write
- colour  out  3  pixel colour
- plot  out  1  write strobe, valid for a single cycle
- alive  out  NUM_PLAYERS  live-player mask
- game_over  out  1  high while in OVER
- winner  out  2  index of the sole survivor
- winner_valid  out  1  exactly one survivor at game end
- step_count  out  16  steps since start, saturates at 16'hFFFF

Behaviour:
- Reset (asynchronous, reset low):
  - state=IDLE; plot, alive, game_over, winner, winner_valid, step_count, x, y, colour all 0.
  - Pending turn requests and the tick counter are cleared.
- Direction encoding: 0=right, 1=down, 2=left, 3=up.
  - Right turn: dir+1 mod 4. Left turn: dir-1 mod 4.
- Turn requests:
  - Rising edges on turn_left[i] / turn_right[i] set a pending request, held until the next MOVE and cleared there.
  - If both left and right are pending, no turn occurs.
  - Multiple edges of the same kind between steps count as one turn.
- Start positions for player i:
  - x = GRID_W*(i+1)/(NUM_PLAYERS+1), integer division
  - y = GRID_H/2
  - dir = 0 for even i, 2 for odd i
- Colours: player 0 = 3'b100, player 1 = 3'b001, player 2 = 3'b010, player 3 = 3'b110.
- IDLE:
  - start=1 -> INIT.
- INIT:
  - Load start positions and directions; alive=all ones; step_count=0; game_over=0; winner_valid=0.
  - Then plot each player's start pixel, one per cycle, players 0..NUM_PLAYERS-1 in order.
  - Then -> WAIT.
- WAIT:
  - Tick counter counts 0..STEP_DIV-1; at terminal count -> MOVE and the counter reloads 0.
  - start is ignored.
- MOVE (1 cycle):
  - Every alive player applies its pending turn, then advances one cell in its direction.
  - step_count increments, saturating.
- CHECK (1 cycle): an alive player dies if any of the following holds.
  - (a) Its new position is outside the grid. Compare with a signed/extended range so that stepping left from x=0 is out of range rather than wrapping.
  - (b) Its new position equals another alive player's new position.
  - (c) It swapped cells with another alive player (head-on crossing).
  - Deaths are simultaneous; every player meeting a condition dies in the same step.
- DRAW:
  - NUM_PLAYERS cycles, slot i outputs player i's x/y/colour.
  - plot=1 only if player i is still alive; dead slots have plot=0 with x/y/colour don't-care.
  - Exits to OVER if the alive count is ≤1 (NUM_PLAYERS≥2) or 0 (NUM_PLAYERS=1); else to WAIT.
- OVER:
  - game_over=1.
  - Exactly one alive: winner=its index, winner_valid=1. Otherwise winner=0, winner_valid=0.
  - start=1 -> INIT (new game; the screen is not cleared by this block).
- Dead players keep their last in-grid position, receive no turns and are never plotted again.
- plot is never high outside INIT/DRAW.
- Reset mid-DRAW drops plot in the same reset assertion, without waiting for a clock edge.

Optional Feature:
- TRON_WALL_WRAP_EN defined:
  - Leaving the grid wraps: x=GRID_W-1 moving right -> 0, x=0 moving left -> GRID_W-1, same for y with GRID_H.
  - Condition (a) is removed; only conditions (b) and (c) kill.
- Undefined: wall exit kills, as above.

Test Plan:
- NUM_PLAYERS=2, STEP_DIV=4, start pulse:
  - INIT plots (53,60,3'b100) then (106,60,3'b001).
  - After the first step, DRAW plots (54,60) and (105,60); step_count=1.
- Player 0 gives one turn_right edge during WAIT:
  - The next step moves it from (54,60) to (54,61).
  - A further left+right edge pair in the same interval: no turn, next position (54,62).
- Player 0 driven upward to y=0, one more step:
  - alive=2'b10, game_over=1, winner=1, winner_valid=1.
  - With TRON_WALL_WRAP_EN: position becomes y=119 and both players stay alive.
- GRID_W=6: starts at x=2 and x=4, facing each other:
  - Step 1 lands both on x=3 -> both die, game_over=1, winner_valid=0.
  - Odd-gap variant (players adjacent): the swap kills both.
- Reset asserted low mid-DRAW with plot=1:
  - plot, alive and step_count go to 0 without a clock edge.
  - After release, start re-enters INIT.
- In OVER, start pulse:
  - INIT replots the start pixels, alive=2'b11, game_over=0, step_count=0.
